io_input_ctrl: RTL and testbench

Memory-mapped input controller for the board's keys and switches. It synchronizes and debounces the raw inputs, latches each debounced change into a data register with sticky ready and overrun flags, and serves processor loads with a read-to-clear handshake. It sits beside the output-side IO memory on the data-memory bus and answers the KEY/SW data addresses plus two control/status addresses.

---
 rtl/io_addr_pkg.sv | 35 +++
 rtl/input_debouncer.sv | 57 +++++
 rtl/io_input_ctrl.sv | 160 ++++++++++++++++
 tb/tb_io_input_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_addr_pkg.sv
// Shared IO address map, CTRL register bit layout and debounce default.
// Imported by the input controller and by the output-side IO memory.
package io_addr_pkg;

    localparam logic [31:0] ADDR_KEY    = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW     = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL  = 32'hF000_0110;
    localparam logic [31:0] ADDR_SWCTRL = 32'hF000_0114;

    localparam int READY   = 0;
    localparam int OVERRUN = 2;
    localparam int IE      = 4;

    localparam int DEBOUNCE_CYCLES = 100000;

    localparam int NUM_KEYS     = 4;
    localparam int NUM_SWITCHES = 10;

    typedef struct packed {
        logic ie;
        logic overrun;
        logic ready;
    } ctrl_t;

    // Places the CTRL flags at their bus bit positions; unused bits read 0.
    function automatic logic [IE:0] ctrl_word(input ctrl_t c);
        logic [IE:0] w;
        w          = '0;
        w[READY]   = c.ready;
        w[OVERRUN] = c.overrun;
        w[IE]      = c.ie;
        return w;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// One-bit input conditioner: two-flop synchronizer followed by a debounce
// counter that only accepts a level held for DEBOUNCE_CYCLES cycles.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = io_addr_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          stable_reg;
    logic          stable_next;
    logic          changed_reg;
    logic          changed_next;

    // Any cycle where the synchronized level matches the accepted level
    // restarts the count, so short bounces leave nothing behind.
    always_comb begin
        cnt_next     = '0;
        stable_next  = stable_reg;
        changed_next = 1'b0;
        if (sync_reg[1] != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next  = ~stable_reg;
                changed_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            stable_reg  <= 1'b0;
            changed_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], din};
            cnt_reg     <= cnt_next;
            stable_reg  <= stable_next;
            changed_reg <= changed_next;
        end
    end

    assign stable  = stable_reg;
    assign changed = changed_reg;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped key/switch input controller: debounced inputs are latched into
// per-group data registers with sticky ready/overrun flags and read-to-clear.
module io_input_ctrl #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = io_addr_pkg::DEBOUNCE_CYCLES,
    parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(io_addr_pkg::ADDR_KEY),
    parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(io_addr_pkg::ADDR_SW),
    parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(io_addr_pkg::ADDR_KCTRL),
    parameter logic [DBITS-1:0] ADDR_SWCTRL     = DBITS'(io_addr_pkg::ADDR_SWCTRL)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       keys,
    input  logic [9:0]       switches,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [DBITS-1:0] data_in,
    output logic [DBITS-1:0] data_out,
    output logic             irq
);

    import io_addr_pkg::ctrl_t;
    import io_addr_pkg::ctrl_word;
    import io_addr_pkg::READY;
    import io_addr_pkg::OVERRUN;
    import io_addr_pkg::IE;
    import io_addr_pkg::NUM_KEYS;
    import io_addr_pkg::NUM_SWITCHES;

    localparam int NIN     = NUM_KEYS + NUM_SWITCHES;
    localparam int NGRP    = 2;
    localparam int GRP_KEY = 0;
    localparam int GRP_SW  = 1;

    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] stable_vec;
    logic [NIN-1:0] changed_vec;

    assign raw_in = {switches, keys};

    genvar gi;
    generate
        for (gi = 0; gi < NIN; gi++) begin : g_deb
            input_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .reset_n(reset_n),
                .din    (raw_in[gi]),
                .stable (stable_vec[gi]),
                .changed(changed_vec[gi])
            );
        end
    endgenerate

    logic [NGRP-1:0]            grp_event;
    logic [NGRP-1:0][DBITS-1:0] grp_vector;
    logic [NGRP-1:0][DBITS-1:0] grp_daddr;
    logic [NGRP-1:0][DBITS-1:0] grp_caddr;
    logic [NGRP-1:0][DBITS-1:0] grp_data;
    ctrl_t [NGRP-1:0]           grp_ctrl;
    logic [NGRP-1:0]            grp_rd_clr;
    logic [NGRP-1:0]            grp_ctrl_wr;

    assign grp_event[GRP_KEY]  = |changed_vec[NUM_KEYS-1:0];
    assign grp_event[GRP_SW]   = |changed_vec[NIN-1:NUM_KEYS];
    assign grp_vector[GRP_KEY] = DBITS'(stable_vec[NUM_KEYS-1:0]);
    assign grp_vector[GRP_SW]  = DBITS'(stable_vec[NIN-1:NUM_KEYS]);
    assign grp_daddr[GRP_KEY]  = ADDR_KEY;
    assign grp_daddr[GRP_SW]   = ADDR_SW;
    assign grp_caddr[GRP_KEY]  = ADDR_KCTRL;
    assign grp_caddr[GRP_SW]   = ADDR_SWCTRL;

    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [DBITS-1:0] data_reg;
            ctrl_t            ctrl_reg;
            ctrl_t            ctrl_next;

            assign grp_rd_clr[gi]  = rd_en && (addr == grp_daddr[gi]);
            assign grp_ctrl_wr[gi] = wr_en && (addr == grp_caddr[gi]);

            // A store can only clear overrun; an event landing while ready is
            // still pending (and not being read away) sets it regardless.
            always_comb begin
                ctrl_next = ctrl_reg;
                if (grp_ctrl_wr[gi]) begin
                    ctrl_next.ie = data_in[IE];
                    if (!data_in[OVERRUN]) begin
                        ctrl_next.overrun = 1'b0;
                    end
                end
                if (grp_event[gi]) begin
                    ctrl_next.ready = 1'b1;
                    if (ctrl_reg.ready && !grp_rd_clr[gi]) begin
                        ctrl_next.overrun = 1'b1;
                    end
                end else if (grp_rd_clr[gi]) begin
                    ctrl_next.ready = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg <= '0;
                    ctrl_reg <= '0;
                end else begin
                    ctrl_reg <= ctrl_next;
                    if (grp_event[gi]) begin
                        data_reg <= grp_vector[gi];
                    end
                end
            end

            assign grp_data[gi] = data_reg;
            assign grp_ctrl[gi] = ctrl_reg;
        end
    endgenerate

    logic [DBITS-1:0] rd_data;
    logic             irq_next;
    logic [DBITS-1:0] data_out_reg;
    logic             irq_reg;

    // Reads see pre-update register contents, so a read racing an event
    // returns the previous data.
    always_comb begin
        rd_data  = '0;
        irq_next = 1'b0;
        for (int g = 0; g < NGRP; g++) begin
            if (addr == grp_daddr[g]) begin
                rd_data = grp_data[g];
            end
            if (addr == grp_caddr[g]) begin
                rd_data = DBITS'(ctrl_word(grp_ctrl[g]));
            end
            irq_next = irq_next | (grp_ctrl[g].ready & grp_ctrl[g].ie);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            data_out_reg <= rd_en ? rd_data : '0;
            irq_reg      <= irq_next;
        end
    end

    assign data_out = data_out_reg;
    assign irq      = irq_reg;

    // Only the ie and overrun bits of a store carry meaning.
    logic unused_data_bits;
    assign unused_data_bits = ^{data_in[DBITS-1:IE+1], data_in[IE-1:OVERRUN+1],
                                data_in[OVERRUN-1:READY]};

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a window-based reference model.
module tb_io_input_ctrl;

    localparam int D = 4;
    localparam logic [31:0] A_KEY    = 32'hF0000010;
    localparam logic [31:0] A_SW     = 32'hF0000014;
    localparam logic [31:0] A_KCTRL  = 32'hF0000110;
    localparam logic [31:0] A_SWCTRL = 32'hF0000114;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b1;
    logic [3:0]  keys     = '0;
    logic [9:0]  switches = '0;
    logic [31:0] addr     = '0;
    logic        rd_en    = 1'b0;
    logic        wr_en    = 1'b0;
    logic [31:0] data_in  = '0;
    logic [31:0] data_out;
    logic        irq;

    always #5 clk = ~clk;

    io_input_ctrl #(
        .DBITS          (32),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .keys    (keys),
        .switches(switches),
        .addr    (addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // An input bit is accepted once the synchronized samples seen on the last
    // D edges (since reset) all disagree with the accepted level.
    logic [13:0] hist[$];
    int          n_edges;
    logic [13:0] m_stable;
    logic [13:0] m_flip;
    logic [31:0] m_data[2];
    bit          m_rdy[2];
    bit          m_ovr[2];
    bit          m_ie[2];
    logic [31:0] m_dout;
    bit          m_irq;

    function automatic void model_reset();
        hist.delete();
        n_edges  = 0;
        m_stable = '0;
        m_flip   = '0;
        m_dout   = '0;
        m_irq    = 1'b0;
        for (int g = 0; g < 2; g++) begin
            m_data[g] = '0;
            m_rdy[g]  = 1'b0;
            m_ovr[g]  = 1'b0;
            m_ie[g]   = 1'b0;
        end
    endfunction

    // Synchronized value available at edge m = raw input seen two edges earlier.
    function automatic logic [13:0] sample_at(int m);
        if (m >= 3) return hist[m-3];
        return '0;
    endfunction

    function automatic logic [31:0] m_ctrl(int g);
        return {27'b0, m_ie[g], 1'b0, m_ovr[g], 1'b0, m_rdy[g]};
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        case (a)
            A_KEY:    return m_data[0];
            A_SW:     return m_data[1];
            A_KCTRL:  return m_ctrl(0);
            A_SWCTRL: return m_ctrl(1);
            default:  return '0;
        endcase
    endfunction

    function automatic void model_step();
        logic [31:0] daddr[2];
        logic [31:0] caddr[2];
        logic [13:0] s;
        bit          evt, clr, cw, all_diff;
        daddr[0] = A_KEY;   daddr[1] = A_SW;
        caddr[0] = A_KCTRL; caddr[1] = A_SWCTRL;
        m_dout = rd_en ? m_read(addr) : 32'h0;
        m_irq  = (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1]);
        for (int g = 0; g < 2; g++) begin
            evt = (g == 0) ? (|m_flip[3:0]) : (|m_flip[13:4]);
            clr = rd_en && (addr == daddr[g]);
            cw  = wr_en && (addr == caddr[g]);
            if (cw) begin
                m_ie[g] = data_in[4];
                if (!data_in[2]) m_ovr[g] = 1'b0;
            end
            if (evt) begin
                if (m_rdy[g] && !clr) m_ovr[g] = 1'b1;
                m_rdy[g]  = 1'b1;
                m_data[g] = (g == 0) ? {28'b0, m_stable[3:0]} : {22'b0, m_stable[13:4]};
            end else if (clr) begin
                m_rdy[g] = 1'b0;
            end
        end
        hist.push_back({switches, keys});
        n_edges++;
        m_flip = '0;
        if (n_edges >= D) begin
            for (int b = 0; b < 14; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    s = sample_at(n_edges - k);
                    if (s[b] == m_stable[b]) all_diff = 1'b0;
                end
                m_flip[b] = all_diff;
            end
        end
        m_stable = m_stable ^ m_flip;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_dout", data_out, m_dout);
        check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic bus(bit r, bit w, logic [31:0] a, logic [31:0] d);
        rd_en   = r;
        wr_en   = w;
        addr    = a;
        data_in = d;
        cycle();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = '0;
        data_in = '0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return A_KEY;
            1:       return A_SW;
            2:       return A_KCTRL;
            3:       return A_SWCTRL;
            4:       return 32'hF0000018;
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        string       name;
        int          bounce;
        logic [3:0]  k;
        logic [9:0]  s;
        int          hold;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_dout;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string name, int bounce, logic [3:0] k, logic [9:0] s, int hold,
                                bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                                logic [31:0] exp_dout, bit exp_irq);
        vec_t v;
        v.name = name; v.bounce = bounce; v.k = k; v.s = s; v.hold = hold;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.exp_dout = exp_dout; v.exp_irq = exp_irq;
        tbl.push_back(v);
    endfunction

    initial begin
        int saw_irq;

        add("idle",          0, 4'h0, 10'h000, 20, 0, 0, 32'h0,    32'h0,  32'h0,   0);
        add("kctrl_rst",     0, 4'h0, 10'h000,  0, 1, 0, A_KCTRL,  32'h0,  32'h0,   0);
        add("swctrl_rst",    0, 4'h0, 10'h000,  0, 1, 0, A_SWCTRL, 32'h0,  32'h0,   0);
        add("key_rst",       0, 4'h0, 10'h000,  0, 1, 0, A_KEY,    32'h0,  32'h0,   0);
        add("swctrl_ready",  0, 4'h0, 10'h2AA,  8, 1, 0, A_SWCTRL, 32'h0,  32'h1,   0);
        add("sw_data",       0, 4'h0, 10'h2AA,  0, 1, 0, A_SW,     32'h0,  32'h2AA, 0);
        add("swctrl_clr",    0, 4'h0, 10'h2AA,  0, 1, 0, A_SWCTRL, 32'h0,  32'h0,   0);
        add("kctrl_bounce", 20, 4'h0, 10'h2AA, 10, 1, 0, A_KCTRL,  32'h0,  32'h0,   0);
        add("key_settle",    0, 4'h5, 10'h2AA, 10, 0, 0, 32'h0,    32'h0,  32'h0,   0);
        add("kctrl_overrun", 0, 4'h1, 10'h2AA, 10, 1, 0, A_KCTRL,  32'h0,  32'h5,   0);
        add("key_data",      0, 4'h1, 10'h2AA,  0, 1, 0, A_KEY,    32'h0,  32'h1,   0);
        add("kctrl_wr0",     0, 4'h1, 10'h2AA,  0, 0, 1, A_KCTRL,  32'h0,  32'h0,   0);
        add("kctrl_cleared", 0, 4'h1, 10'h2AA,  0, 1, 0, A_KCTRL,  32'h0,  32'h0,   0);
        add("kctrl_wr_ie",   0, 4'h1, 10'h2AA,  0, 0, 1, A_KCTRL,  32'h10, 32'h0,   0);
        add("kctrl_ie",      0, 4'h1, 10'h2AA,  0, 1, 0, A_KCTRL,  32'h0,  32'h10,  0);
        add("kctrl_irq",     0, 4'h3, 10'h2AA, 10, 1, 0, A_KCTRL,  32'h0,  32'h11,  1);
        add("key_rd_irq",    0, 4'h3, 10'h2AA,  0, 1, 0, A_KEY,    32'h0,  32'h3,   1);
        add("irq_drop",      0, 4'h3, 10'h2AA,  0, 0, 0, 32'h0,    32'h0,  32'h0,   0);
        add("sw_wr_ignored", 0, 4'h3, 10'h2AA,  0, 0, 1, A_SW,     32'hFF, 32'h0,   0);
        add("sw_kept",       0, 4'h3, 10'h2AA,  0, 1, 0, A_SW,     32'h0,  32'h2AA, 0);
        add("unmapped_rd",   0, 4'h3, 10'h2AA,  0, 1, 0, 32'hF0000018, 32'h0, 32'h0, 0);

        // Power-on reset with a real falling edge on reset_n.
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        check("rst_init_dout", data_out, 32'h0);
        check("rst_init_irq", {31'b0, irq}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            for (int t = 0; t < tbl[i].bounce / 2; t++) begin
                keys = (t % 2 == 0) ? 4'b0101 : 4'b0000;
                idle(2);
            end
            keys     = tbl[i].k;
            switches = tbl[i].s;
            idle(tbl[i].hold);
            bus(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
            $display("vec %-14s dout=%h irq=%0d", tbl[i].name, data_out, irq);
            check(tbl[i].name, data_out, tbl[i].exp_dout);
            check({tbl[i].name, "_irq"}, {31'b0, irq}, {31'b0, tbl[i].exp_irq});
        end

        // Event latency and a read landing on the very event edge (ie=1, ready=0 here).
        keys    = 4'h7;
        saw_irq = 0;
        for (int e = 1; e <= 6; e++) begin
            idle(1);
            if (irq) saw_irq = 1;
        end
        check("irq_pre_event", saw_irq, 0);
        bus(1, 0, A_KEY, 32'h0);
        $display("evt edge read dout=%h irq=%0d", data_out, irq);
        check("evt_rd_old", data_out, 32'h3);
        check("evt_rd_irq0", {31'b0, irq}, 32'h0);
        idle(1);
        check("evt_irq_rise", {31'b0, irq}, 32'h1);
        bus(1, 0, A_KCTRL, 32'h0);
        check("evt_ready_kept", data_out, 32'h11);

        // Asynchronous reset while switches are mid-debounce.
        switches = 10'h3FF;
        idle(1);
        bus(1, 0, A_SW, 32'h0);
        check("sw_pre_reset", data_out, 32'h2AA);
        reset_n = 1'b0;
        model_reset();
        #1;
        $display("async reset dout=%h irq=%0d", data_out, irq);
        check("rst_async_dout", data_out, 32'h0);
        check("rst_async_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus(1, 0, A_KCTRL, 32'h0);
        check("rst_kctrl", data_out, 32'h0);
        idle(4);
        bus(1, 0, A_SW, 32'h0);
        check("sw_pre_debounce", data_out, 32'h0);
        idle(1);
        bus(1, 0, A_SW, 32'h0);
        $display("post reset SW read dout=%h", data_out);
        check("sw_post_reset", data_out, 32'h3FF);

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) keys = 4'($urandom);
            if ($urandom_range(0, 15) == 0) switches = 10'($urandom);
            case ($urandom_range(0, 9))
                0, 1: begin rd_en = 1'b1; wr_en = 1'b0; end
                2:    begin rd_en = 1'b0; wr_en = 1'b1; end
                3:    begin rd_en = 1'b1; wr_en = 1'b1; end
                default: begin rd_en = 1'b0; wr_en = 1'b0; end
            endcase
            addr    = pick_addr();
            data_in = $urandom;
            cycle();
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        $display("random phase done at %0d checks", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
